// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between a CPU core and a debug port.
// The core normally owns the memory and completes its access in the same cycle
// (combinational read data, write committed at the clock edge). The debug port
// is served whenever the core is not requesting. It uses a valid/ready request
// channel and a valid/ready read-response channel.
//
// Optional feature, selected by the macro DMEM_ARB_STARVE_GUARD_EN:
//   When the macro is defined, a starvation guard counts the cycles a debug
//   request waits behind the core. After MAX_WAIT waiting cycles it forces a
//   one-cycle debug grant and stalls the core for that cycle.
//   When the macro is undefined, the core has strict priority, core_stall is
//   tied to 0, and debug waits for as long as core_req stays high.
//
// Handshake rule, used by both debug channels: a beat transfers on a rising
// clk edge where valid and ready are both 1. The source holds valid and its
// payload until that edge. The sink may look at valid when it drives ready
// (dbg_ready depends on dbg_valid when the guard fires). Valid never depends
// on ready.
//
// Parameters
//   DATA_W    memory word width
//   ADDR_W    word-index width
//   MAX_WAIT  debug wait cycles before a forced grant (1..15, guard build only)
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   core_req/we/addr/wdata        core access, byte address, same-cycle service
//   core_rdata                    core read data (memory read data, passed through)
//   core_stall                    core access not serviced this cycle
//   dbg_valid/ready/we/addr/wdata debug request channel (word address)
//   dbg_rvalid/rready/rdata       debug read-response channel
//   mem_we/addr/wdata/rdata       memory port: combinational read, synchronous write
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,

  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,

  output logic              dbg_rvalid,
  input  logic              dbg_rready,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t              state;
  logic                is_idle;
  logic                forced;
  logic                core_go;
  logic                dbg_xfer;
  logic [ADDR_W-1:0]   core_idx;

  // The core index takes only the word-index bits of the byte address, so
  // accesses wrap modulo the memory depth. The remaining address bits are
  // intentionally unused.
  logic                unused_core_addr_bits;
  assign core_idx              = core_addr[ADDR_W+1:2];
  assign unused_core_addr_bits = ^{core_addr[31:ADDR_W+2], core_addr[1:0]};

  assign is_idle = (state == ST_IDLE);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  // The grant is forced only in the cycle where the counter sits at its limit.
  // A forced debug transfer clears the counter again.
  assign forced = is_idle && dbg_valid && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (dbg_xfer || !dbg_valid) begin
      wait_cnt <= 4'd0;
    end else if (is_idle && !dbg_ready && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  // Ownership is decided combinationally each cycle.
  assign core_go    = core_req && !forced;
  assign core_stall = core_req && forced;
  assign dbg_ready  = is_idle && (!core_req || forced);
  assign dbg_xfer   = dbg_valid && dbg_ready;

  // Memory port mux. Only one side can drive a write, because debug owns the
  // port only in cycles where the core does not. Writes are also blocked while
  // reset is asserted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = core_idx;
    mem_wdata = core_wdata;
    if (core_go) begin
      mem_we    = core_we;
      mem_addr  = core_idx;
      mem_wdata = core_wdata;
    end else if (dbg_ready) begin
      mem_we    = dbg_valid && dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  assign core_rdata = mem_rdata;

  // Debug response FSM. Read data is captured at the transfer edge and held
  // until the response is accepted. Debug writes never leave IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dbg_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dbg_xfer && !dbg_we) begin
            state     <= ST_RESP;
            dbg_rdata <= mem_rdata;
          end
        end
        ST_RESP: begin
          if (dbg_rready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_rvalid = (state == ST_RESP);

  // Invariants of the arbitration
  a_no_dual_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(core_go && core_we && dbg_xfer && dbg_we));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    dbg_ready |-> is_idle);

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (dbg_rvalid && !dbg_rready) |=> (dbg_rvalid && $stable(dbg_rdata)));

endmodule
